// File: rtl/neuron_tick_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : neuron_tick_scheduler
//  Description : Sequences one neuromorphic tick. It scans the latched axon
//                spikes and issues one row integration per set bit, then
//                requests the fire phase and captures the resulting spikes.
//  Revision    : 1.0 - initial release
// ============================================================================
module neuron_tick_scheduler #(
    parameter int NUM_AXONS   = 256,
    parameter int NUM_NEURONS = 256,
    parameter int IDX_W       = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start_i,
    input  logic                           abort_i,
    input  logic [NUM_AXONS-1:0]           axon_spikes_i,
    output logic                           axon_valid_o,
    output logic [IDX_W-1:0]               axon_idx_o,
    input  logic                           axon_ready_i,
    output logic                           fire_o,
    input  logic                           fire_ready_i,
    input  logic [NUM_NEURONS-1:0]         neuron_spikes_i,
    output logic [NUM_NEURONS-1:0]         spike_vec_o,
    output logic [$clog2(NUM_NEURONS):0]   spike_count_o,
    output logic [15:0]                    tick_count_o,
    output logic                           busy_o,
    output logic                           done_o
);

    localparam int               c_CNT_W    = $clog2(NUM_NEURONS) + 1;
    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(NUM_AXONS - 1);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_SCAN    = 3'd1;
    localparam logic [2:0] c_ISSUE   = 3'd2;
    localparam logic [2:0] c_FIRE    = 3'd3;
    localparam logic [2:0] c_CAPTURE = 3'd4;
    localparam logic [2:0] c_DONE    = 3'd5;

    logic [2:0]             r_state;
    logic [IDX_W-1:0]       r_idx;
    logic [NUM_AXONS-1:0]   r_latched;
    logic [NUM_NEURONS-1:0] r_spike_vec;
    logic [c_CNT_W-1:0]     r_spike_count;
    logic [15:0]            r_tick_count;
    logic                   r_axon_valid;
    logic                   r_fire;
    logic                   r_busy;
    logic                   r_done;
    logic [c_CNT_W-1:0]     w_popcount;

    always_comb begin
        w_popcount = '0;
        for (int i = 0; i < NUM_NEURONS; i++) begin
            w_popcount = w_popcount + c_CNT_W'(neuron_spikes_i[i]);
        end
    end

    // Handshake outputs are registered alongside the state so they change on
    // exactly the edge that enters or leaves ISSUE / FIRE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_IDLE;
            r_idx         <= '0;
            r_latched     <= '0;
            r_spike_vec   <= '0;
            r_spike_count <= '0;
            r_tick_count  <= '0;
            r_axon_valid  <= 1'b0;
            r_fire        <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else if (abort_i && (r_state != c_IDLE)) begin
            r_state      <= c_IDLE;
            r_axon_valid <= 1'b0;
            r_fire       <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (start_i && !abort_i) begin
                        r_latched <= axon_spikes_i;
                        r_idx     <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= c_SCAN;
                    end
                end
                c_SCAN: begin
                    if (r_latched[r_idx]) begin
                        r_axon_valid <= 1'b1;
                        r_state      <= c_ISSUE;
                    end else if (r_idx == c_LAST_IDX) begin
                        r_fire  <= 1'b1;
                        r_state <= c_FIRE;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                c_ISSUE: begin
                    if (axon_ready_i) begin
                        r_axon_valid <= 1'b0;
                        if (r_idx == c_LAST_IDX) begin
                            r_fire  <= 1'b1;
                            r_state <= c_FIRE;
                        end else begin
                            r_idx   <= r_idx + IDX_W'(1);
                            r_state <= c_SCAN;
                        end
                    end
                end
                c_FIRE: begin
                    if (fire_ready_i) begin
                        r_fire  <= 1'b0;
                        r_state <= c_CAPTURE;
                    end
                end
                c_CAPTURE: begin
                    r_spike_vec   <= neuron_spikes_i;
                    r_spike_count <= w_popcount;
                    r_tick_count  <= r_tick_count + 16'd1;
                    r_done        <= 1'b1;
                    r_state       <= c_DONE;
                end
                c_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= c_IDLE;
                end
                default: begin
                    r_axon_valid <= 1'b0;
                    r_fire       <= 1'b0;
                    r_busy       <= 1'b0;
                    r_state      <= c_IDLE;
                end
            endcase
        end
    end

    assign axon_valid_o  = r_axon_valid;
    assign axon_idx_o    = r_idx;
    assign fire_o        = r_fire;
    assign spike_vec_o   = r_spike_vec;
    assign spike_count_o = r_spike_count;
    assign tick_count_o  = r_tick_count;
    assign busy_o        = r_busy;
    assign done_o        = r_done;

endmodule
`default_nettype wire

// File: doc/neuron_tick_scheduler.md
NEURON_TICK_SCHEDULER -- requirements
Module: neuron_tick_scheduler

Interface
REQ-001 SHALL have parameter NUM_AXONS, default 256, number of synapse-matrix rows (axons) scanned per tick.
REQ-002 SHALL have parameter NUM_NEURONS, default 256, width of the neuron spike vector.
REQ-003 SHALL have parameter IDX_W, default 8, axon index width; the design requires NUM_AXONS <= 2^IDX_W.
REQ-004 SHALL have port clk, input, 1, the single clock.
REQ-005 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-006 SHALL have port start_i, input, 1, a one-cycle request to run one tick.
REQ-007 SHALL have port abort_i, input, 1, which cancels the tick in progress.
REQ-008 SHALL have port axon_spikes_i, input, NUM_AXONS, the input spike vector for the tick.
REQ-009 SHALL have port axon_valid_o, output, 1, which requests integration of the row at axon_idx_o.
REQ-010 SHALL have port axon_idx_o, output, IDX_W, the index of the active axon row.
REQ-011 SHALL have port axon_ready_i, input, 1, the row-integration acknowledge from the neuron datapath.
REQ-012 SHALL have port fire_o, output, 1, which requests the leak/threshold/fire phase.
REQ-013 SHALL have port fire_ready_i, input, 1, the fire-phase acknowledge.
REQ-014 SHALL have port neuron_spikes_i, input, NUM_NEURONS, the spike vector from the neuron blocks.
REQ-015 SHALL have port spike_vec_o, output, NUM_NEURONS, the spike vector captured for the last completed tick.
REQ-016 SHALL have port spike_count_o, output, $clog2(NUM_NEURONS)+1, the popcount of spike_vec_o.
REQ-017 SHALL have port tick_count_o, output, 16, the number of completed ticks.
REQ-018 SHALL have port busy_o, output, 1, high in every state except IDLE.
REQ-019 SHALL have port done_o, output, 1, a one-cycle pulse at tick completion.

Function
REQ-020 SHALL implement the states IDLE, SCAN, ISSUE, FIRE, CAPTURE and DONE.
REQ-021 In IDLE, start_i=1 and abort_i=0 SHALL do three things on the same edge: latch axon_spikes_i into an internal copy, clear idx to 0, and enter SCAN.
REQ-022 Changes on axon_spikes_i after the start edge SHALL be ignored for the rest of the tick.
REQ-023 SCAN SHALL examine one latched bit per cycle:
- latched[idx]=1: go to ISSUE.
- latched[idx]=0 and idx < NUM_AXONS-1: increment idx and stay in SCAN.
- latched[idx]=0 and idx = NUM_AXONS-1: go to FIRE.
REQ-024 In ISSUE, axon_valid_o SHALL be 1 and axon_idx_o SHALL equal idx, both held stable until a cycle with axon_ready_i=1.
REQ-025 On the ISSUE edge where axon_ready_i=1, the block SHALL:
- if idx = NUM_AXONS-1: go to FIRE;
- otherwise: increment idx and return to SCAN.
REQ-026 axon_ready_i arriving in the same cycle axon_valid_o first rises SHALL complete the transfer, giving a minimum of 1 cycle in ISSUE.
REQ-027 In FIRE, fire_o SHALL be held at 1 until fire_ready_i=1, then the block SHALL go to CAPTURE.
REQ-028 CAPTURE (1 cycle) SHALL register neuron_spikes_i into spike_vec_o and its popcount into spike_count_o, then go to DONE.
REQ-029 DONE (1 cycle) SHALL assert done_o, increment tick_count_o modulo 2^16 (0xFFFF wraps to 0x0000), and return to IDLE.
REQ-030 axon_valid_o and fire_o SHALL never be high together; both SHALL be 0 outside ISSUE and FIRE respectively.
REQ-031 axon_idx_o SHALL equal idx in every state.
REQ-032 start_i while busy_o=1 SHALL be ignored.
REQ-033 A start_i in the DONE cycle SHALL be ignored; the earliest accepted restart is the IDLE cycle after DONE.
REQ-034 abort_i=1 in any non-IDLE state SHALL, on that edge, return the block to IDLE. The aborted tick SHALL produce no done_o pulse, no tick_count_o increment and no change to spike_vec_o or spike_count_o.
REQ-035 abort_i=1 in IDLE SHALL take precedence over start_i, so the block stays in IDLE.
REQ-036 With an all-zero latched vector, a tick SHALL take NUM_AXONS SCAN cycles, then FIRE, CAPTURE and DONE, with no axon_valid_o pulse.
REQ-037 Latency: for start at edge 0 with zero handshake wait, done_o SHALL be high in cycle NUM_AXONS + k + 3, where k is the number of set latched bits.

Reset
REQ-038 rst=1 SHALL on the next edge force IDLE and clear idx, the latched vector, spike_vec_o, spike_count_o and tick_count_o to 0.
REQ-039 Under reset, busy_o, done_o, axon_valid_o and fire_o SHALL be 0.
REQ-040 Reset mid-tick SHALL override abort_i and start_i, and no partial results SHALL be retained.

Verification
REQ-041 SHALL cover: axon_spikes_i bits {0,5,255}=1, ready tied high -> axon_valid_o pulses with idx 0, 5, 255 in order, fire_o once, done_o in cycle 262.
REQ-042 SHALL cover: all-zero axons, neuron_spikes_i=0xF0 -> no axon_valid_o, spike_vec_o=0xF0, spike_count_o=4, tick_count_o=1.
REQ-043 SHALL cover: axon 7 set, axon_ready_i delayed 3 cycles -> axon_valid_o and axon_idx_o=7 held stable for 4 cycles.
REQ-044 SHALL cover: abort_i during ISSUE of the second tick -> IDLE next cycle, no done_o, tick_count_o stays 1, spike_vec_o unchanged.
REQ-045 SHALL cover: tick_count_o preset to 0xFFFF via 65535 fast all-zero ticks (or force) -> next tick gives 0x0000.
REQ-046 SHALL cover: rst asserted in FIRE -> IDLE, all outputs 0; start_i pulsed while busy -> ignored.
